// File: rtl/debug_capture_ctrl.sv
// Capture sequencer for the 4-bit change-detect debugger: timestamps trigger events into a FWFT FIFO.
// Optional DEBUG_CAPTURE_TIMEOUT_EN ends a CAPTURE session after 2**TS_W-1 trigger-free cycles.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | session limit latched, waiting for first trigger
// CAPTURE | timestamp running, recording events until limit
// DRAIN   | no more events, waiting for FIFO to empty
module debug_capture_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_W       = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              trigger,
    input  logic [3:0]        data,
    input  logic [7:0]        max_samples,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TS_W+3:0]   out_data,
    output logic              busy,
    output logic              overflow,
    output logic              done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DW    = TS_W + 4;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t          state, state_next;
    logic [8:0]      limit, count, count_next;
    logic [TS_W-1:0] ts, ts_next;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [DW-1:0]   mem [DEPTH];
    logic            empty, full, pop, push, drop, event_hit, arm_accept;
    logic [DW-1:0]   sample;
`ifdef DEBUG_CAPTURE_TIMEOUT_EN
    logic [TS_W-1:0] idle_cnt;
`endif

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign event_hit  = trigger && ((state == ARMED) || (state == CAPTURE));
    // A pop in the same cycle frees a slot, so a full FIFO still takes the event.
    assign push       = event_hit && (!full || pop);
    assign drop       = event_hit && !push;
    assign arm_accept = (state == IDLE) && arm;
    assign sample     = {((state == ARMED) ? '0 : ts), data};
    assign out_data   = empty ? '0 : mem[rd_ptr[PW-2:0]];
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        count_next = count;
        ts_next    = ts;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = ARMED;
                    count_next = '0;
                    ts_next    = '0;
                end
            end
            ARMED: begin
                ts_next = '0;
                if (trigger) begin
                    // first sample took timestamp 0; counter continues from 1
                    ts_next    = TS_W'(1);
                    count_next = 9'd1;
                    state_next = (limit == 9'd1) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                ts_next = ts + TS_W'(1);
                if (trigger) begin
                    count_next = count + 9'd1;
                    if ((count + 9'd1) == limit)
                        state_next = DRAIN;
                end
`ifdef DEBUG_CAPTURE_TIMEOUT_EN
                else if (idle_cnt == '1) begin
                    state_next = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (empty) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            limit    <= '0;
            count    <= '0;
            ts       <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            ts    <= ts_next;
            if (arm_accept)
                limit <= (max_samples == 8'd0) ? 9'd256 : {1'b0, max_samples};
            if (arm_accept)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PW-2:0]] <= sample;
    end

`ifdef DEBUG_CAPTURE_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if ((state != CAPTURE) || trigger)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TS_W'(1);
    end
`endif

endmodule

// File: tb/tb_debug_capture_ctrl.sv
// Scoreboard bench for debug_capture_ctrl: directed sessions push expected samples,
// a negedge monitor pops and compares on every accepted output beat.
module tb_debug_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        trigger;
    logic [3:0]  data;
    logic [7:0]  max_samples;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        overflow;
    logic        done;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          pops = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_head;

    debug_capture_ctrl #(.DEPTH_LOG2(4), .TS_W(12)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trigger(trigger), .data(data),
        .max_samples(max_samples), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (done)
                done_cnt++;
            if (out_valid && out_ready) begin
                pops++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got %h, required no output", out_data);
                end else begin
                    exp_head = exp_q.pop_front();
                    if (out_data !== exp_head) begin
                        fails++;
                        $display("FAIL sb_data: got %h, required %h", out_data, exp_head);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic arm_session(input logic [7:0] ms);
        arm = 1'b1;
        max_samples = ms;
        cyc();
        arm = 1'b0;
        @(negedge clk);
        check("busy_after_arm", busy, 1);
        check("overflow_cleared_on_arm", overflow, 0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        arm = 1'b0;
        trigger = 1'b0;
        data = 4'h0;
        max_samples = 8'd0;
        out_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        cyc();

        // basic session: timestamps relative to first trigger
        done_cnt = 0;
        out_ready = 1'b1;
        exp_q.push_back({12'd0, 4'd1});
        exp_q.push_back({12'd5, 4'd2});
        exp_q.push_back({12'd12, 4'd3});
        arm_session(8'd3);
        for (int i = 0; i < 31; i++) begin
            trigger = (i == 10) || (i == 15) || (i == 22);
            data = (i == 10) ? 4'd1 : (i == 15) ? 4'd2 : 4'd3;
            cyc();
        end
        trigger = 1'b0;
        wait_idle(20, "t1_idle");
        check("t1_done_once", done_cnt, 1);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_overflow", overflow, 0);

        // overflow: 20 events into a 16-deep FIFO with consumer stalled
        done_cnt = 0;
        pops = 0;
        out_ready = 1'b0;
        arm_session(8'd20);
        for (int i = 0; i < 20; i++) begin
            trigger = 1'b1;
            data = 4'(i);
            if (i < 16)
                exp_q.push_back({12'(i), 4'(i)});
            cyc();
        end
        trigger = 1'b0;
        cyc();
        @(negedge clk);
        check("t2_overflow", overflow, 1);
        check("t2_valid_held", out_valid, 1);
        check("t2_busy_drain", busy, 1);
        check("t2_no_done_yet", done_cnt, 0);
        out_ready = 1'b1;
        wait_idle(40, "t2_idle");
        check("t2_pops", pops, 16);
        check("t2_done_once", done_cnt, 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // full FIFO with simultaneous pop and push
        done_cnt = 0;
        out_ready = 1'b0;
        arm_session(8'd17);
        for (int i = 0; i < 16; i++) begin
            trigger = 1'b1;
            data = 4'(i);
            exp_q.push_back({12'(i), 4'(i)});
            cyc();
        end
        trigger = 1'b1;
        data = 4'hA;
        out_ready = 1'b1;
        exp_q.push_back({12'd16, 4'hA});
        cyc();
        trigger = 1'b0;
        @(negedge clk);
        check("t3_overflow_clear", overflow, 0);
        check("t3_valid", out_valid, 1);
        wait_idle(40, "t3_idle");
        check("t3_done_once", done_cnt, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // max_samples=0 means 256 events
        done_cnt = 0;
        out_ready = 1'b1;
        arm_session(8'd0);
        for (int i = 0; i < 255; i++) begin
            trigger = 1'b1;
            data = 4'(i);
            exp_q.push_back({12'(i), 4'(i)});
            cyc();
        end
        trigger = 1'b0;
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        check("t4_busy_after_255", busy, 1);
        check("t4_fifo_empty", out_valid, 0);
        check("t4_no_done_255", done_cnt, 0);
        trigger = 1'b1;
        data = 4'h5;
        exp_q.push_back({12'd258, 4'h5});
        cyc();
        trigger = 1'b0;
        wait_idle(5, "t4_idle_after_256");
        check("t4_done_once", done_cnt, 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // reset during CAPTURE with 5 samples buffered
        done_cnt = 0;
        out_ready = 1'b0;
        arm_session(8'd10);
        for (int i = 0; i < 5; i++) begin
            trigger = 1'b1;
            data = 4'(i + 3);
            cyc();
        end
        trigger = 1'b0;
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        check("t5_no_done", done_cnt, 0);
        exp_q.push_back({12'd0, 4'd5});
        exp_q.push_back({12'd1, 4'd6});
        arm_session(8'd2);
        trigger = 1'b1;
        data = 4'd5;
        cyc();
        data = 4'd6;
        cyc();
        trigger = 1'b0;
        wait_idle(10, "t5_idle");
        check("t5_done_once", done_cnt, 1);
        check("t5_queue_empty", exp_q.size(), 0);

        // session limit not reached: timeout only when the option is built in
        done_cnt = 0;
        out_ready = 1'b1;
        exp_q.push_back({12'd0, 4'd7});
        exp_q.push_back({12'd1, 4'd8});
        arm_session(8'd10);
        trigger = 1'b1;
        data = 4'd7;
        cyc();
        data = 4'd8;
        cyc();
        trigger = 1'b0;
`ifdef DEBUG_CAPTURE_TIMEOUT_EN
        wait_idle(4200, "t6_timeout_idle");
        check("t6_done_once", done_cnt, 1);
`else
        for (int i = 0; i < 4200; i++)
            cyc();
        @(negedge clk);
        check("t6_still_capture", busy, 1);
        check("t6_no_done", done_cnt, 0);
        for (int j = 0; j < 8; j++) begin
            trigger = 1'b1;
            data = 4'(9 + j);
            exp_q.push_back({12'(4202 + j), 4'(9 + j)});
            cyc();
        end
        trigger = 1'b0;
        wait_idle(10, "t6_idle");
        check("t6_done_once", done_cnt, 1);
`endif
        check("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
